// File: rtl/cc_hazard_ctrl.sv
// cc_hazard_ctrl: carry/zero condition-code tracking, forwarding, predication and load-zero stall
module cc_hazard_ctrl #(
    parameter logic RESET_C = 1'b0,
    parameter logic RESET_Z = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic       ex_valid,
    input  logic       ex_flush,
    input  logic [1:0] ex_cond,
    input  logic       ex_wr_c,
    input  logic       ex_wr_z,
    input  logic       ex_is_load,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       mem_load_zero,
    output logic       ex_exec,
    output logic       stall_req,
    output logic       fwd_carry,
    output logic       fwd_zero,
    output logic       for_carry,
    output logic       for_zero
);
    typedef struct packed {
        logic v;
        logic wc;
        logic wz;
        logic ld;
        logic c;
        logic z;
    } mem_rec_t;

    typedef struct packed {
        logic v;
        logic wc;
        logic wz;
        logic c;
        logic z;
    } wb_rec_t;

    mem_rec_t mem_rec;
    wb_rec_t  wb_rec;
    logic     haz;
    logic     cond_ok;

    // Youngest in-flight write wins: MEM, then WB, then the architected flag
    always_comb begin
        fwd_carry = (mem_rec.v && mem_rec.wc) ? mem_rec.c :
                    (wb_rec.v && wb_rec.wc)   ? wb_rec.c  : for_carry;
        fwd_zero  = (mem_rec.v && mem_rec.wz) ? mem_rec.z :
                    (wb_rec.v && wb_rec.wz)   ? wb_rec.z  : for_zero;
    end

    // A zero-predicated op behind a load in MEM must wait for the load data's zero
    always_comb begin
        haz       = ex_valid & ~ex_flush & (ex_cond == 2'b10) & mem_rec.v & mem_rec.wz & mem_rec.ld;
        stall_req = haz & ~hold;
        cond_ok   = (ex_cond == 2'b01) ? fwd_carry :
                    (ex_cond == 2'b10) ? fwd_zero  : 1'b1;
        ex_exec   = ex_valid & ~ex_flush & ~haz & ~hold & cond_ok;
    end

    // Advance the MEM/WB flag records and commit the WB write to the architected flags
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rec   <= '0;
            wb_rec    <= '0;
            for_carry <= RESET_C;
            for_zero  <= RESET_Z;
        end else if (!hold) begin
            if (wb_rec.v && wb_rec.wc) for_carry <= wb_rec.c;
            if (wb_rec.v && wb_rec.wz) for_zero <= wb_rec.z;
            wb_rec  <= {mem_rec.v, mem_rec.wc, mem_rec.wz, mem_rec.c,
                        mem_rec.ld ? mem_load_zero : mem_rec.z};
            mem_rec <= {ex_exec, ex_wr_c, ex_wr_z, ex_is_load, alu_carry, alu_zero};
        end
    end
endmodule

// File: tb/tb_cc_hazard_ctrl.sv
// tb_cc_hazard_ctrl: directed vector table plus randomized run against a queue-based flag model
module tb_cc_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset, hold, ex_valid, ex_flush;
    logic [1:0] ex_cond;
    logic       ex_wr_c, ex_wr_z, ex_is_load, alu_carry, alu_zero, mem_load_zero;
    logic       ex_exec, stall_req, fwd_carry, fwd_zero, for_carry, for_zero;

    cc_hazard_ctrl dut (
        .clk(clk), .reset(reset), .hold(hold), .ex_valid(ex_valid), .ex_flush(ex_flush),
        .ex_cond(ex_cond), .ex_wr_c(ex_wr_c), .ex_wr_z(ex_wr_z), .ex_is_load(ex_is_load),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .mem_load_zero(mem_load_zero),
        .ex_exec(ex_exec), .stall_req(stall_req), .fwd_carry(fwd_carry), .fwd_zero(fwd_zero),
        .for_carry(for_carry), .for_zero(for_zero)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // exp = {ex_exec, stall_req, fwd_carry, fwd_zero, for_carry, for_zero}
    typedef struct {
        bit rst, hld, v, fl;
        bit [1:0] cond;
        bit wc, wz, ld, ac, az, mlz;
        bit chk;
        bit [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit hld, bit v, bit fl, bit [1:0] cond, bit wc, bit wz,
                                bit ld, bit ac, bit az, bit mlz, bit c, bit [5:0] exp);
        vec_t t;
        t.rst = rst; t.hld = hld; t.v = v; t.fl = fl; t.cond = cond;
        t.wc = wc; t.wz = wz; t.ld = ld; t.ac = ac; t.az = az; t.mlz = mlz;
        t.chk = c; t.exp = exp;
        return t;
    endfunction

    task automatic drive(input bit rst, input bit hld, input bit v, input bit fl, input bit [1:0] cond,
                         input bit wc, input bit wz, input bit ld, input bit ac, input bit az, input bit mlz);
        reset = rst; hold = hld; ex_valid = v; ex_flush = fl; ex_cond = cond;
        ex_wr_c = wc; ex_wr_z = wz; ex_is_load = ld; alu_carry = ac; alu_zero = az; mem_load_zero = mlz;
    endtask

    task automatic check6(input string tag, input bit [5:0] e);
        chk({tag, ".ex_exec"},   ex_exec,   e[5]);
        chk({tag, ".stall_req"}, stall_req, e[4]);
        chk({tag, ".fwd_carry"}, fwd_carry, e[3]);
        chk({tag, ".fwd_zero"},  fwd_zero,  e[2]);
        chk({tag, ".for_carry"}, for_carry, e[1]);
        chk({tag, ".for_zero"},  for_zero,  e[0]);
    endtask

    // Reference model: list of executed flag writers, youngest first, with pipeline age
    typedef struct {
        bit wc, wz, ld, c, z;
        int age;
    } wr_t;

    wr_t q[$];
    bit  arch_c, arch_z;

    function automatic bit m_fc();
        foreach (q[i]) if (q[i].wc) return q[i].c;
        return arch_c;
    endfunction

    function automatic bit m_fz();
        foreach (q[i]) if (q[i].wz) return q[i].z;
        return arch_z;
    endfunction

    function automatic bit m_haz(bit v, bit fl, bit [1:0] cond);
        return v && !fl && cond == 2'd2 && q.size() > 0 && q[0].age == 0 && q[0].wz && q[0].ld;
    endfunction

    function automatic bit m_exec(bit hld, bit v, bit fl, bit [1:0] cond);
        bit ok;
        ok = (cond == 2'd1) ? m_fc() : (cond == 2'd2) ? m_fz() : 1'b1;
        return v && !fl && !m_haz(v, fl, cond) && !hld && ok;
    endfunction

    task automatic m_edge(input bit rst, input bit hld, input bit ex, input bit wc, input bit wz,
                          input bit ld, input bit ac, input bit az, input bit mlz);
        wr_t n;
        if (rst) begin
            q.delete();
            arch_c = 1'b0;
            arch_z = 1'b0;
        end else if (!hld) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].age == 1) begin
                    if (q[i].wc) arch_c = q[i].c;
                    if (q[i].wz) arch_z = q[i].z;
                    q.delete(i);
                end else begin
                    if (q[i].ld) q[i].z = mlz;
                    q[i].age = 1;
                end
            end
            if (ex) begin
                n.wc = wc; n.wz = wz; n.ld = ld; n.c = ac; n.z = az; n.age = 0;
                q.push_front(n);
            end
        end
    endtask

    initial begin
        // Reset, carry commit latency, carry forwarding, squashed writer
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0, 0, 6'b000000));
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0, 1, 6'b000000));
        tbl.push_back(mk(0,0,1,0,0, 1,0,0,1,0,0, 1, 6'b100000));
        tbl.push_back(mk(0,0,1,0,1, 0,0,0,0,0,0, 1, 6'b101000));
        tbl.push_back(mk(0,0,1,0,1, 0,0,0,0,0,0, 1, 6'b101000));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0, 1, 6'b001010));
        tbl.push_back(mk(0,0,1,0,0, 1,0,0,0,0,0, 1, 6'b101010));
        tbl.push_back(mk(0,0,1,0,1, 1,0,0,1,0,0, 1, 6'b000010));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0, 1, 6'b000010));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0, 1, 6'b000000));
        // Load-zero hazard then forwarded load zero
        tbl.push_back(mk(0,0,1,0,0, 0,1,1,0,0,0, 1, 6'b100000));
        tbl.push_back(mk(0,0,1,0,2, 0,0,0,0,0,1, 1, 6'b010000));
        tbl.push_back(mk(0,0,1,0,2, 0,0,0,0,0,0, 1, 6'b100100));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0, 1, 6'b000101));
        // Back-to-back carry writers: MEM beats WB
        tbl.push_back(mk(0,0,1,0,0, 1,0,0,1,0,0, 1, 6'b100101));
        tbl.push_back(mk(0,0,1,0,0, 1,0,0,0,0,0, 1, 6'b101101));
        tbl.push_back(mk(0,0,1,0,1, 0,0,0,0,0,0, 1, 6'b000101));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0, 1, 6'b000111));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0, 1, 6'b000101));
        // Flush together with hazard
        tbl.push_back(mk(0,0,1,0,0, 0,1,1,0,0,0, 1, 6'b100101));
        tbl.push_back(mk(0,0,1,1,2, 0,0,0,0,0,0, 1, 6'b000001));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0, 1, 6'b000001));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0, 1, 6'b000000));
        // Hold for 3 cycles over a pending hazard
        tbl.push_back(mk(0,0,1,0,0, 0,1,1,0,0,0, 1, 6'b100000));
        tbl.push_back(mk(0,1,1,0,2, 0,0,0,0,0,1, 1, 6'b000000));
        tbl.push_back(mk(0,1,1,0,2, 0,0,0,0,0,1, 1, 6'b000000));
        tbl.push_back(mk(0,1,1,0,2, 0,0,0,0,0,1, 1, 6'b000000));
        tbl.push_back(mk(0,0,1,0,2, 0,0,0,0,0,1, 1, 6'b010000));
        tbl.push_back(mk(0,0,1,0,2, 0,0,0,0,0,0, 1, 6'b100100));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0, 1, 6'b000101));
        // Reset during a stall discards the pending writes
        tbl.push_back(mk(0,0,1,0,0, 1,0,0,1,0,0, 1, 6'b100101));
        tbl.push_back(mk(0,0,1,0,0, 0,1,1,0,0,0, 1, 6'b101101));
        tbl.push_back(mk(1,0,1,0,2, 0,0,0,0,0,1, 1, 6'b011001));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0, 1, 6'b000000));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0, 1, 6'b000000));
        tbl.push_back(mk(0,0,1,0,1, 0,0,0,0,0,0, 1, 6'b000000));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].hld, tbl[i].v, tbl[i].fl, tbl[i].cond, tbl[i].wc, tbl[i].wz,
                  tbl[i].ld, tbl[i].ac, tbl[i].az, tbl[i].mlz);
            #2;
            if (tbl[i].chk) check6($sformatf("tbl%0d", i), tbl[i].exp);
            @(posedge clk);
            #1;
        end

        // Randomized run: start from a reset so DUT and model agree
        drive(1,0,0,0,0, 0,0,0,0,0,0);
        @(posedge clk);
        m_edge(1,0,0, 0,0,0,0,0,0);
        #1;
        for (int n = 0; n < 3000; n++) begin
            bit rst, hld, v, fl, wc, wz, ld, ac, az, mlz, ex, hz;
            bit [1:0] cond;
            rst  = ($urandom_range(0, 63) == 0);
            hld  = ($urandom_range(0, 5) == 0);
            v    = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 7) == 0);
            cond = 2'($urandom_range(0, 3));
            wc = 1'($urandom); wz = 1'($urandom); ld = ($urandom_range(0, 2) == 0);
            ac = 1'($urandom); az = 1'($urandom); mlz = 1'($urandom);
            drive(rst, hld, v, fl, cond, wc, wz, ld, ac, az, mlz);
            #2;
            ex = m_exec(hld, v, fl, cond);
            hz = m_haz(v, fl, cond) && !hld;
            check6($sformatf("rnd%0d", n), {ex, hz, m_fc(), m_fz(), arch_c, arch_z});
            @(posedge clk);
            m_edge(rst, hld, ex, wc, wz, ld, ac, az, mlz);
            #1;
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
